// File: rtl/dmem_pkg.sv
// Shared encodings for the dmem load/store unit: access sizes, FSM states
// and the default dmem size.
package dmem_pkg;

  localparam int MEM_BYTES_DFLT = 1024;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request/response and dmem-side bus of the load/store unit.
// A request transfers on a rising edge where req_valid && req_ready; once
// transferred the request fields are latched and may change freely.
// resp_valid is a single-cycle pulse with no backpressure.
interface dmem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic              mem_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [31:0]       mem_data_out;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_enable, mem_address, mem_data_in, mem_write_enable, mem_read_enable,
    output mem_data_out
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_enable, mem_address, mem_data_in, mem_write_enable, mem_read_enable,
    input  mem_data_out
  );
endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational byte/half alignment: load extraction with sign/zero
// extension, and read-modify-write merge of sub-word store data.
module dmem_lsu_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  always_comb begin
    load_data  = raw_word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{~is_unsigned & raw_word[7]}}, raw_word[7:0]};
        store_word = {raw_word[31:8], wdata[7:0]};
      end
      SZ_HALF: begin
        load_data  = {{16{~is_unsigned & raw_word[15]}}, raw_word[15:0]};
        store_word = {raw_word[31:16], wdata[15:0]};
      end
      default: begin
        load_data  = raw_word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving dmem: one request at a time, byte/half/word loads
// with extension, sub-word stores done as read-modify-write.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DFLT,
  parameter int ADDR_W    = 32
)(
  input  logic         clock,
  input  logic         reset,
  dmem_lsu_if.slave    lsu,
  output lsu_state_e   state_dbg
);

  lsu_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              unsigned_q;
  logic [31:0]       wdata_q;

  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_din_q;

  logic [31:0]       load_data;
  logic [31:0]       store_word;
  logic              req_bad;

  dmem_lsu_align u_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .raw_word    (lsu.mem_data_out),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // The last legal address still has room for the full 4-byte dmem transfer.
  assign req_bad = (lsu.req_size == 2'd3) ||
                   (lsu.req_addr > ADDR_W'(MEM_BYTES - 4));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      case (state)
        ST_IDLE: begin
          if (lsu.req_valid) begin
            addr_q     <= lsu.req_addr;
            size_q     <= lsu.req_size;
            write_q    <= lsu.req_write;
            unsigned_q <= lsu.req_unsigned;
            wdata_q    <= lsu.req_wdata;
            if (req_bad) begin
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (lsu.req_write && lsu.req_size == SZ_WORD) begin
              state      <= ST_WR;
              mem_wr_q   <= 1'b1;
              mem_addr_q <= lsu.req_addr;
              mem_din_q  <= lsu.req_wdata;
            end else begin
              state      <= ST_RD;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= lsu.req_addr;
            end
          end
        end
        ST_RD: state <= ST_CAP;
        // dmem's registered read data is valid now; finish a load or merge a store.
        ST_CAP: begin
          if (write_q) begin
            state      <= ST_WR;
            mem_wr_q   <= 1'b1;
            mem_addr_q <= addr_q;
            mem_din_q  <= store_word;
          end else begin
            state        <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data;
          end
        end
        ST_WR: begin
          state        <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign lsu.req_ready        = (state == ST_IDLE);
  assign lsu.resp_valid       = resp_valid_q;
  assign lsu.resp_rdata       = resp_rdata_q;
  assign lsu.resp_err         = resp_err_q;
  assign lsu.mem_read_enable  = mem_rd_q;
  assign lsu.mem_write_enable = mem_wr_q;
  assign lsu.mem_enable       = mem_rd_q | mem_wr_q;
  assign lsu.mem_address      = mem_addr_q;
  assign lsu.mem_data_in      = mem_din_q;
  assign state_dbg            = state;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-array dmem model, request driver, and a
// scoreboard monitor checking every response against queued expectations.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic       clock;
  logic       reset;
  lsu_state_e state_dbg;

  dmem_lsu_if #(.ADDR_W(32)) lsu ();

  dmem_lsu #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .lsu       (lsu),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int rd_cnt      = 0;
  int wr_cnt      = 0;
  int bus_viol    = 0;
  int ready_viol  = 0;
  int pulse_viol  = 0;
  int resp_cnt    = 0;
  int issued      = 0;
  int last_resp_cyc = 0;
  logic [31:0] last_wdata = '0;
  logic        prev_rv    = 1'b0;

  logic [32:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // dmem model: little-endian, registered read data
  logic [7:0] mem [0:1023];
  always @(posedge clock) begin
    if (!reset) begin
      if (lsu.mem_read_enable) begin
        rd_cnt <= rd_cnt + 1;
        lsu.mem_data_out <= {mem[lsu.mem_address + 3], mem[lsu.mem_address + 2],
                             mem[lsu.mem_address + 1], mem[lsu.mem_address]};
      end
      if (lsu.mem_write_enable) begin
        wr_cnt     <= wr_cnt + 1;
        last_wdata <= lsu.mem_data_in;
        mem[lsu.mem_address]     <= lsu.mem_data_in[7:0];
        mem[lsu.mem_address + 1] <= lsu.mem_data_in[15:8];
        mem[lsu.mem_address + 2] <= lsu.mem_data_in[23:16];
        mem[lsu.mem_address + 3] <= lsu.mem_data_in[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (lsu.mem_read_enable && lsu.mem_write_enable) bus_viol++;
      if (lsu.mem_enable !== (lsu.mem_read_enable | lsu.mem_write_enable)) bus_viol++;
      if (!lsu.mem_read_enable && !lsu.mem_write_enable &&
          (lsu.mem_address != 0 || lsu.mem_data_in != 0)) bus_viol++;
      if (exp_q.size() > 0 && lsu.req_ready) ready_viol++;
      if (lsu.resp_valid) begin
        logic [32:0] e;
        int lat;
        int acc;
        resp_cnt++;
        if (prev_rv) pulse_viol++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual=1 expected=0 rdata=0x%08h", lsu.resp_rdata);
        end else begin
          e   = exp_q.pop_front();
          lat = lat_q.pop_front();
          acc = acc_q.pop_front();
          chk("resp_rdata", lsu.resp_rdata, e[31:0]);
          chk("resp_err", {31'd0, lsu.resp_err}, {31'd0, e[32]});
          chk("resp_latency", cyc - acc + 1, lat);
        end
        last_resp_cyc = cyc;
      end
      prev_rv = lsu.resp_valid;
    end
  end

  // driver: present a request, wait for acceptance, queue its expectation
  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err, input logic [31:0] exp_rd, input int lat,
                      input bit track, input bit hold, input bit b2b);
    int t;
    t = 0;
    @(negedge clock);
    lsu.req_write    = w;
    lsu.req_size     = sz;
    lsu.req_unsigned = u;
    lsu.req_addr     = a;
    lsu.req_wdata    = d;
    lsu.req_valid    = 1'b1;
    while (!lsu.req_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d expected<50 addr=0x%08h", t, a);
      lsu.req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    if (track) begin
      exp_q.push_back({exp_err, exp_rd});
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
      issued++;
    end
    if (b2b) chk("b2b_accept_cycle", cyc, last_resp_cyc + 2);
    if (!hold) lsu.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || state_dbg != ST_IDLE) && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout actual=%0d expected<50", t);
      exp_q.delete(); lat_q.delete(); acc_q.delete();
    end
  endtask

  task automatic chk_bus_idle(input string name);
    chk(name, {lsu.mem_enable, lsu.mem_read_enable, lsu.mem_write_enable}, 32'd0);
    chk({name, "_addr_data"}, lsu.mem_address | lsu.mem_data_in, 32'd0);
  endtask

  initial begin
    int r0;
    int w0;
    reset            = 1'b1;
    lsu.req_valid    = 1'b0;
    lsu.req_write    = 1'b0;
    lsu.req_size     = 2'd0;
    lsu.req_unsigned = 1'b0;
    lsu.req_addr     = '0;
    lsu.req_wdata    = '0;

    // reset state
    @(negedge clock);
    chk("rst_resp", {lsu.resp_valid, lsu.resp_err, 30'd0} | lsu.resp_rdata, 32'd0);
    chk_bus_idle("rst_bus");
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", {31'd0, lsu.req_ready}, 32'd1);

    // word store / word load
    r0 = rd_cnt; w0 = wr_cnt;
    send(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2, 1, 0, 0);
    wait_done();
    chk("wstore_wr_strobes", wr_cnt - w0, 1);
    chk("wstore_rd_strobes", rd_cnt - r0, 0);
    send(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0, 0);

    // preloads
    send(1, SZ_WORD, 0, 32'h20, 32'h11223344, 0, 32'h0, 2, 1, 0, 0);
    send(1, SZ_WORD, 0, 32'h30, 32'h0000F080, 0, 32'h0, 2, 1, 0, 0);
    send(1, SZ_WORD, 0, 32'h40, 32'h55667788, 0, 32'h0, 2, 1, 0, 0);
    send(1, SZ_WORD, 0, 32'd1020, 32'hCAFEF00D, 0, 32'h0, 2, 1, 0, 0);
    wait_done();

    // byte store read-modify-write
    r0 = rd_cnt; w0 = wr_cnt;
    send(1, SZ_BYTE, 0, 32'h20, 32'h123456AB, 0, 32'h0, 4, 1, 0, 0);
    wait_done();
    chk("bstore_rd_strobes", rd_cnt - r0, 1);
    chk("bstore_wr_strobes", wr_cnt - w0, 1);
    chk("bstore_merged", last_wdata, 32'h112233AB);
    send(0, SZ_WORD, 0, 32'h20, 32'h0, 0, 32'h112233AB, 3, 1, 0, 0);

    // extension
    send(0, SZ_BYTE, 0, 32'h30, 32'h0, 0, 32'hFFFFFF80, 3, 1, 0, 0);
    send(0, SZ_BYTE, 1, 32'h30, 32'h0, 0, 32'h00000080, 3, 1, 0, 0);
    send(0, SZ_HALF, 0, 32'h30, 32'h0, 0, 32'hFFFFF080, 3, 1, 0, 0);
    send(0, SZ_HALF, 1, 32'h30, 32'h0, 0, 32'h0000F080, 3, 1, 0, 0);

    // half store read-modify-write
    send(1, SZ_HALF, 0, 32'h20, 32'hAAAA5678, 0, 32'h0, 4, 1, 0, 0);
    wait_done();
    chk("hstore_merged", last_wdata, 32'h11225678);
    send(0, SZ_WORD, 0, 32'h20, 32'h0, 0, 32'h11225678, 3, 1, 0, 0);

    // bounds and reserved size
    send(0, SZ_WORD, 0, 32'd1020, 32'h0, 0, 32'hCAFEF00D, 3, 1, 0, 0);
    wait_done();
    r0 = rd_cnt; w0 = wr_cnt;
    send(0, SZ_WORD, 0, 32'd1021, 32'h0, 1, 32'h0, 1, 1, 0, 0);
    send(0, 2'd3, 0, 32'h10, 32'h0, 1, 32'h0, 1, 1, 0, 0);
    send(1, SZ_BYTE, 0, 32'hFFFF_FFF0, 32'h77, 1, 32'h0, 1, 1, 0, 0);
    wait_done();
    chk("err_no_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);

    // reset during CAP of a sub-word store
    w0 = wr_cnt;
    send(1, SZ_BYTE, 0, 32'h40, 32'h99, 0, 32'h0, 4, 0, 0, 0);
    begin
      int t;
      t = 0;
      while (state_dbg != ST_CAP && t < 20) begin
        @(negedge clock);
        t++;
      end
      chk("reach_cap", 32'(state_dbg), 32'(ST_CAP));
    end
    reset = 1'b1;
    #1;
    chk_bus_idle("midrst_bus");
    chk("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("midrst_req_ready", {31'd0, lsu.req_ready}, 32'd1);
    chk_bus_idle("midrst_bus_after");
    chk("midrst_no_write", wr_cnt - w0, 0);
    send(0, SZ_WORD, 0, 32'h40, 32'h0, 0, 32'h55667788, 3, 1, 0, 0);
    wait_done();

    // req_valid held across two loads
    send(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 1, 1, 0);
    send(0, SZ_HALF, 1, 32'h20, 32'h0, 0, 32'h00005678, 3, 1, 0, 1);
    wait_done();
    repeat (3) @(negedge clock);

    // protocol-wide checks
    chk("bus_rules", bus_viol, 0);
    chk("ready_low_while_busy", ready_viol, 0);
    chk("resp_single_pulse", pulse_viol, 0);
    chk("resp_count", resp_cnt, issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
